aes_cipher_core: RTL and testbench

//  AES-128 encryption datapath; sits directly downstream of key_expand.

---
 rtl/aes_pkg.sv | 26 ++
 rtl/aes_sbox.sv | 30 +++
 rtl/aes_cipher_core.sv | 141 ++++++++++++++
 tb/tb_aes_cipher_core.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-128 shared types, sizing constants and GF(2^8) column arithmetic.
// Latency: none (types and combinational functions only).
// Backpressure: n/a.
package aes_pkg;

  localparam int NB = 4;   // columns per state
  localparam int NR = 10;  // AES-128 round count

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, OUT} fsm_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column; bits[31:24] hold row 0
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box lookup, one byte.
// Latency: combinational.
// Backpressure: none.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s_o = SBOX[a_i];

endmodule

// File: rtl/aes_cipher_core.sv
// AES-128 column-serial encryption: 4-word load, 10 rounds of 4 columns, 4-word output.
// Latency: start at T -> ciphertext words at T+45..T+48, done from T+49.
// Backpressure: none; start is ignored while busy or while key_ready is low.
module aes_cipher_core
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        key_ready,
  input  logic [31:0] data_in,
  output logic [3:0]  round_key_num,
  output logic [1:0]  r_index,
  input  logic [31:0] round_key,
  output logic [31:0] data_out,
  output logic        out_valid,
  output logic        busy,
  output logic        done
);

  fsm_t                 state_q, state_d;
  logic [1:0]           col_q, col_d;
  logic [3:0]           rnd_q, rnd_d;
  logic                 done_q, done_d;
  logic [NB-1:0][31:0]  st_q;
  logic [NB-2:0][31:0]  nx_q;

  logic        last_col;
  logic [7:0]  sb_in  [NB];
  logic [7:0]  sb_out [NB];
  logic [31:0] sb_col;
  logic [31:0] col_res;

  assign last_col = (col_q == 2'(NB - 1));

  // ShiftRows gather from the old state, then SubBytes per row
  for (genvar r = 0; r < NB; r++) begin : g_row
    logic [1:0] src;
    assign src       = col_q + 2'(r);
    assign sb_in[r]  = st_q[src][8*(3-r) +: 8];
    aes_sbox u_sbox (.a_i(sb_in[r]), .s_o(sb_out[r]));
  end

  assign sb_col  = {sb_out[0], sb_out[1], sb_out[2], sb_out[3]};
  assign col_res = ((state_q == FINAL) ? sb_col : mix_column(sb_col)) ^ round_key;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && key_ready)                state_d = LOAD;
      LOAD:    if (last_col)                          state_d = ROUND;
      ROUND:   if (last_col && rnd_q == 4'(NR - 1))   state_d = FINAL;
      FINAL:   if (last_col)                          state_d = OUT;
      OUT:     if (last_col)                          state_d = IDLE;
      default:                                        state_d = IDLE;
    endcase
  end

  // Output decode: key index, ciphertext word and status flags
  always_comb begin
    round_key_num = 4'd0;
    r_index       = 2'd0;
    data_out      = 32'h0;
    out_valid     = 1'b0;
    busy          = (state_q != IDLE);
    done          = done_q;
    case (state_q)
      LOAD:        r_index = col_q;
      ROUND, FINAL: begin
        round_key_num = rnd_q;
        r_index       = col_q;
      end
      OUT: begin
        out_valid = 1'b1;
        data_out  = st_q[col_q];
      end
      default: ;
    endcase
  end

  // Column / round counters and done flag next values
  always_comb begin
    col_d  = (state_q == IDLE) ? 2'd0 : col_q + 2'd1;
    rnd_d  = rnd_q;
    done_d = done_q;
    case (state_q)
      IDLE:  if (start && key_ready) done_d = 1'b0;
      LOAD:  if (last_col) rnd_d = 4'd1;
      ROUND: if (last_col) rnd_d = rnd_q + 4'd1;
      FINAL: if (last_col) rnd_d = 4'd0;
      OUT:   if (last_col) done_d = 1'b1;
      default: ;
    endcase
  end

  // Counter and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q  <= 2'd0;
      rnd_q  <= 4'd0;
      done_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      rnd_q  <= rnd_d;
      done_q <= done_d;
    end
  end

  // Cipher state: columns 0-2 park in nx_q so ShiftRows keeps reading the old round
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= '0;
      nx_q <= '0;
    end else begin
      case (state_q)
        LOAD: st_q[col_q] <= data_in ^ round_key;
        ROUND, FINAL: begin
          if (last_col) begin
            st_q[0] <= nx_q[0];
            st_q[1] <= nx_q[1];
            st_q[2] <= nx_q[2];
            st_q[3] <= col_res;
          end else begin
            nx_q[col_q] <= col_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Self-checking bench: byte-matrix AES reference, key_expand stand-in, ciphertext scoreboard.
// Latency: checks the start-to-output timing and the round-key index walk.
// Backpressure: exercises ignored starts, reset abort and back-to-back starts.
module tb_aes_cipher_core;

  logic        clk = 1'b0;
  logic        reset, start, key_ready;
  logic [31:0] data_in, round_key, data_out;
  logic [3:0]  round_key_num;
  logic [1:0]  r_index;
  logic        out_valid, busy, done;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_start;
  logic done_after_start;

  logic [7:0]  sbt [256];
  logic [31:0] kw  [44];
  logic [31:0] exp_q [$];

  logic rk_mon = 1'b0;
  int   rk_i, rk_err;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K3 = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] P3 = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] C3 = 128'h29c3505f571420f6402299b31a02d73a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_cipher_core #(.NR(10)) dut (
    .clk(clk), .reset(reset), .start(start), .key_ready(key_ready),
    .data_in(data_in), .round_key_num(round_key_num), .r_index(r_index),
    .round_key(round_key), .data_out(data_out), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  // key_expand stand-in: combinational readout of the expanded key schedule
  always_comb begin
    round_key = 32'h0;
    if (round_key_num <= 4'd10) round_key = kw[{round_key_num, r_index}];
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then affine map
  task automatic build_sbox();
    logic [7:0] b, r1, r2, r3, r4;
    for (int x = 0; x < 256; x++) begin
      b = 8'h0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      r1 = {b[6:0], b[7]};
      r2 = {r1[6:0], r1[7]};
      r3 = {r2[6:0], r2[7]};
      r4 = {r3[6:0], r3[7]};
      sbt[x] = b ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] k);
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) kw[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = kw[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbt[tmp[31:24]], sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      kw[i] = kw[i-4] ^ tmp;
    end
  endtask

  // Reference cipher on a 4x4 byte matrix s[row][col]
  function automatic logic [127:0] aes_model(input logic [127:0] pt);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-32*c-8*r -: 8] ^ kw[c][31-8*r -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbt[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rd < 10)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                    ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = s[r][c] ^ kw[4*rd+c][31-8*r -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-32*c-8*r -: 8] = s[r][c];
    return res;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every presented ciphertext word must match the queue head
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got data_out %h expected no output", data_out);
      end else begin
        chk("ct_word", 128'(data_out), 128'(exp_q.pop_front()));
      end
    end
  end

  // Round-key index walk monitor
  always @(negedge clk) begin
    if (rk_mon && busy && !out_valid) begin
      if (int'(round_key_num) != rk_i / 4 || int'(r_index) != rk_i % 4) rk_err++;
      rk_i++;
    end
  end

  // Issue start at the current negedge and feed plaintext words on T+1..T+4
  task automatic send(input logic [127:0] pt, input logic [127:0] ct, input logic push);
    start   = 1'b1;
    t_start = cyc;
    if (push) for (int w = 0; w < 4; w++) exp_q.push_back(ct[127-32*w -: 32]);
    @(negedge clk);
    start            = 1'b0;
    done_after_start = done;
    for (int w = 0; w < 4; w++) begin
      data_in = pt[127-32*w -: 32];
      @(negedge clk);
    end
    data_in = $urandom;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    chk(nm, 128'(done), 128'(1));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k, p;
    reset = 1'b0; start = 1'b0; key_ready = 1'b0; data_in = 32'h0;
    build_sbox();
    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'({data_out, out_valid, busy, done, round_key_num, r_index}), 128'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 128'({busy, done, out_valid}), 128'(0));

    // Reference model against the published vectors
    set_key(K2); chk("model_c2", aes_model(P2), C2);
    set_key(K3); chk("model_c3", aes_model(P3), C3);
    set_key(K1); chk("model_c1", aes_model(P1), C1);
    key_ready = 1'b1;

    // Test 1 with starts issued while busy
    send(P1, C1, 1'b1);
    while (cyc < t_start + 10) @(negedge clk);
    pulse_start();
    while (cyc < t_start + 30) @(negedge clk);
    pulse_start();
    wait_done("t1_done");

    // Start without key_ready is ignored
    key_ready = 1'b0;
    pulse_start();
    repeat (4) @(negedge clk);
    chk("no_start_wo_key", 128'(busy), 128'(0));
    key_ready = 1'b1;

    // Test 3 with exact output timing
    set_key(K3);
    send(P3, C3, 1'b1);
    while (cyc < t_start + 44) @(negedge clk);
    chk("ov_before_T45", 128'({out_valid, busy}), 128'(2'b01));
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      chk("ov_window", 128'({out_valid, busy, done, round_key_num, r_index}), 128'(9'b110_0000_00));
    end
    @(negedge clk);
    chk("done_T49", 128'({out_valid, busy, done}), 128'(3'b001));

    // Reset in the middle of a run, then rerun
    send(P3, C3, 1'b1);
    while (cyc < t_start + 20) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_reset_outputs", 128'({data_out, out_valid, busy, done, round_key_num, r_index}), 128'(0));
    end
    reset = 1'b1;
    @(negedge clk);
    chk("done_low_after_abort", 128'(done), 128'(0));
    send(P3, C3, 1'b1);
    wait_done("t5_done");

    // Test 2, then back-to-back start in the first done cycle
    set_key(K2);
    send(P2, C2, 1'b1);
    wait_done("t2_done");
    rk_i = 0; rk_err = 0; rk_mon = 1'b1;
    send(P2, C2, 1'b1);
    chk("done_drops_after_start", 128'(done_after_start), 128'(0));
    wait_done("t6_done");
    rk_mon = 1'b0;
    chk("rk_walk_len", 128'(rk_i), 128'(44));
    chk("rk_walk_err", 128'(rk_err), 128'(0));

    // Randomized keys and plaintexts against the reference model
    for (int n = 0; n < 6; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      set_key(k);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(p, aes_model(p), 1'b1);
      wait_done("rand_done");
    end

    @(negedge clk);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
